// File: rtl/serial_addsub_ctrl.sv
// Bit-serial two's-complement adder/subtractor with its controller FSM, counter and datapath.
// Processes one bit per clock, LSB first, and holds the parallel result after completion.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             SER_OUT,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum;
  logic             w_carry_next;
  logic             w_last;

  // Full adder on the current LSBs; r_carry is the carry into the bit being processed.
  assign w_sum        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last       = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (START)  w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  if (!START) w_next = ST_IDLE;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sr     <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with the mode bit.
            r_a     <= A_IN;
            r_b     <= SUB ? ~B_IN : B_IN;
            r_carry <= SUB;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sr    <= {w_sum, r_sr[WIDTH-1:1]};
          r_carry <= w_carry_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // On the final bit r_carry still holds the carry into the MSB.
            r_result <= {w_sum, r_sr[WIDTH-1:1]};
            r_cout   <= w_carry_next;
            r_ovf    <= r_carry ^ w_carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY    = (r_state == ST_SHIFT);
  assign DONE    = (r_state == ST_DONE);
  assign SER_OUT = BUSY & w_sum;
  assign RESULT  = r_result;
  assign COUT    = r_cout;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: directed vectors push expected results,
// per-instance monitors pop and compare whenever DONE rises.
module tb_serial_addsub_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, sub, busy, done, ser_out, cout, ovf;
  logic [7:0]  a_in, b_in, result;
  logic        start16, sub16, busy16, done16, ser16, cout16, ovf16;
  logic [15:0] a16, b16, result16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   n_checks = 0;
  int   n_errors = 0;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start), .SUB(sub), .A_IN(a_in), .B_IN(b_in),
    .BUSY(busy), .DONE(done), .SER_OUT(ser_out), .RESULT(result), .COUT(cout), .OVF(ovf)
  );

  serial_addsub_ctrl #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .START(start16), .SUB(sub16), .A_IN(a16), .B_IN(b16),
    .BUSY(busy16), .DONE(done16), .SER_OUT(ser16), .RESULT(result16), .COUT(cout16), .OVF(ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: collects SER_OUT bits while BUSY, checks on DONE rise.
  int          bc8 = 0;
  logic [31:0] ser8 = '0;
  logic        pd8 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      bc8  = 0;
      ser8 = '0;
    end else begin
      if (busy) begin
        if (bc8 < 32) ser8[bc8] = ser_out;
        bc8++;
      end
      if (done && !pd8) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          check("busy_cycles8", bc8, 32'd8);
          check("ser_out_seq8", ser8, e8.res);
          check("result8", {24'b0, result}, e8.res);
          check("cout8", {31'b0, cout}, {31'b0, e8.c});
          check("ovf8", {31'b0, ovf}, {31'b0, e8.o});
        end
        bc8  = 0;
        ser8 = '0;
      end
    end
    pd8 = done;
  end

  // Monitor for the 16-bit instance.
  int          bc16 = 0;
  logic [31:0] ser16v = '0;
  logic        pd16 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      bc16   = 0;
      ser16v = '0;
    end else begin
      if (busy16) begin
        if (bc16 < 32) ser16v[bc16] = ser16;
        bc16++;
      end
      if (done16 && !pd16) begin
        if (q16.size() == 0) begin
          check("unexpected_done16", 32'd1, 32'd0);
        end else begin
          e16 = q16.pop_front();
          check("busy_cycles16", bc16, 32'd16);
          check("ser_out_seq16", ser16v, e16.res);
          check("result16", {16'b0, result16}, e16.res);
          check("cout16", {31'b0, cout16}, {31'b0, e16.c});
          check("ovf16", {31'b0, ovf16}, {31'b0, e16.o});
        end
        bc16   = 0;
        ser16v = '0;
      end
    end
    pd16 = done16;
  end

  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("timeout_done8", 32'd0, 32'd1);
  endtask

  task automatic wait_done16();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done16) return;
    end
    check("timeout_done16", 32'd0, 32'd1);
  endtask

  // Drives operands with START high through one launch edge; START is left high.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] res, input logic c, input logic o, input bit expect_done);
    @(posedge clk) #1;
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    if (expect_done) q8.push_back('{res: {24'b0, res}, c: c, o: o});
    @(posedge clk) #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] res, input logic c, input logic o);
    launch8(a, b, s, res, c, o, 1'b1);
    start = 1'b0;
    wait_done8();
    @(posedge clk) #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] res, input logic c, input logic o);
    @(posedge clk) #1;
    a16     = a;
    b16     = b;
    sub16   = s;
    start16 = 1'b1;
    q16.push_back('{res: {16'b0, res}, c: c, o: o});
    @(posedge clk) #1;
    start16 = 1'b0;
    wait_done16();
    @(posedge clk) #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    sub     = 1'b0;
    a_in    = 8'h3C;
    b_in    = 8'h25;
    start16 = 1'b0;
    sub16   = 1'b0;
    a16     = '0;
    b16     = '0;

    // Reset held with START high: everything stays cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {24'b0, result}, 32'h00);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_ser_out", {31'b0, ser_out}, 32'd0);

    // Release reset with START still high: launch on the next edge (0x3C + 0x25).
    @(posedge clk) #1;
    rst = 1'b0;
    q8.push_back('{res: 32'h61, c: 1'b0, o: 1'b0});
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    check("launch_after_reset_busy", {31'b0, busy}, 32'd1);
    wait_done8();
    @(posedge clk) #1;

    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // START held through DONE: DONE stays, no relaunch, IDLE one edge after START drops.
    launch8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
    wait_done8();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_start_done", {31'b0, done}, 32'd1);
      check("held_start_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    check("done_before_exit", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_result_held", {24'b0, result}, 32'h08);
    check("idle_ser_out", {31'b0, ser_out}, 32'd0);

    // Operand and mode changes after launch are ignored.
    launch8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    repeat (2) @(posedge clk) #1;
    a_in = 8'hFF;
    b_in = 8'h00;
    sub  = 1'b1;
    wait_done8();
    @(posedge clk) #1;

    // START re-pulsed mid-SHIFT does not restart (monitor still sees exactly 8 BUSY cycles).
    launch8(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    repeat (3) @(posedge clk) #1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    wait_done8();
    @(posedge clk) #1;

    // Reset sampled on the 4th SHIFT edge aborts with nothing retained.
    launch8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {24'b0, result}, 32'h00);
    check("abort_cout", {31'b0, cout}, 32'd0);
    check("abort_ovf", {31'b0, ovf}, 32'd0);
    repeat (12) @(negedge clk);

    // 16-bit instance.
    run16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run16(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q16_drained", q16.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
